ff_bank_rr_ctrl: RTL

- Controller for a small register bank built from positive-edge flip-flop cells.
- Arbitrates single-word writes from two requesters using a round-robin req/gnt handshake.
- Provides one registered read port.
- Sits between the synthesized datapath and the technology-mapped flop bank. It is the only path that loads the bank.

---
 rtl/ff_bank_pkg.sv | 14 +
 rtl/ff_bank_rr_arb.sv | 81 ++++++++
 rtl/ff_bank_rr_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared FSM state and pointer encodings
// for the round-robin flop-bank write controller.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic PTR_REQ0 = 1'b0;
  localparam logic PTR_REQ1 = 1'b1;

endpackage

// File: rtl/ff_bank_rr_arb.sv
// ff_bank_rr_arb: round-robin req/gnt FSM for two writers.
// Grants decode from registered state only.
module ff_bank_rr_arb
  import ff_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic busy,
  output logic wr_sel
);

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;

  // state and pointer registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= PTR_REQ0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // next state: the granted requester's own req is ignored
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      ST_IDLE: begin
        if (req0 && req1)
          state_nxt = (ptr == PTR_REQ0) ? ST_GNT0 : ST_GNT1;
        else if (req0)
          state_nxt = ST_GNT0;
        else if (req1)
          state_nxt = ST_GNT1;
        else
          state_nxt = ST_IDLE;
      end
      ST_GNT0: begin
        ptr_nxt   = PTR_REQ1;
        state_nxt = req1 ? ST_GNT1 : ST_IDLE;
      end
      ST_GNT1: begin
        ptr_nxt   = PTR_REQ0;
        state_nxt = req0 ? ST_GNT0 : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // outputs decoded from the state register
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    busy   = 1'b0;
    wr_sel = 1'b0;
    unique case (1'b1)
      (state == ST_GNT0): begin
        gnt0 = 1'b1;
        busy = 1'b1;
      end
      (state == ST_GNT1): begin
        gnt1   = 1'b1;
        busy   = 1'b1;
        wr_sel = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ff_bank_rr_ctrl.sv
// ff_bank_rr_ctrl: flop bank, write mux and read register.
// Optional write-through forwarding: FF_BANK_BYPASS_EN.
module ff_bank_rr_ctrl
  import ff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  logic [WIDTH-1:0] bank [DEPTH];
  logic             wr_sel;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             wr_ok;
  logic             rd_ok;

  ff_bank_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .busy   (busy),
    .wr_sel (wr_sel)
  );

  // write mux follows the granted requester
  always_comb begin
    waddr = wr_sel ? addr1 : addr0;
    wdata = wr_sel ? wdata1 : wdata0;
  end

  if (DEPTH < (2 ** AW)) begin : g_part
    assign wr_ok = 32'(waddr) < DEPTH;
    assign rd_ok = 32'(raddr) < DEPTH;
  end else begin : g_full
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end

  // bank load on the closing edge of a grant cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        bank[i] <= '0;
    end else if (busy && wr_ok) begin
      bank[waddr] <= wdata;
    end
  end

  // registered read, out-of-range reads give 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
`ifdef FF_BANK_BYPASS_EN
    end else if (busy && wr_ok && (waddr == raddr)) begin
      rdata <= wdata;
`endif
    end else if (rd_ok) begin
      rdata <= bank[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule
